// File: rtl/rv_instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder: micro-op in,
// encoded word with its byte address out, plus reject reporting and a consumed-word count.
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [1:0]        in_alu;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [12:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [15:0]       word_count;

    modport master (
        output in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_valid, err_code, word_count
    );

    modport slave (
        input  in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_valid, err_code, word_count
    );
endinterface

// File: rtl/rv_instr_encoder.sv
// Packs decoded micro-ops (R-type, LW, SW, BEQ) into RV32I words and streams them
// through a 2-entry FIFO, tagging each word with an incrementing byte address.
module rv_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    rv_instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        KIND_R   = 2'b00,
        KIND_LW  = 2'b01,
        KIND_SW  = 2'b10,
        KIND_BEQ = 2'b11
    } kind_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ODD   = 2'b10
    } err_t;

    logic [31:0]       mem [2];
    logic              head;
    logic [1:0]        count;
    logic              started;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wcount;
    logic              errv;
    err_t              errc;

    kind_t       kind;
    err_t        code;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;
    logic        tail;
    logic [6:0]  f7;
    logic [2:0]  f3;

    assign kind   = kind_t'(bus.in_kind);
    assign tail   = head ^ count[0];

    // Ready comes only from occupancy and the post-reset start flag; flush forces it low.
    assign bus.in_ready = started && (count != 2'd2) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && (code == ERR_NONE);
    assign pop          = (count != 2'd0) && bus.out_ready && !flush;

    always_comb begin
        code = ERR_NONE;
        if ((kind == KIND_LW || kind == KIND_SW) && (bus.in_imm[12] != bus.in_imm[11]))
            code = ERR_RANGE;
        else if (kind == KIND_BEQ && bus.in_imm[0])
            code = ERR_ODD;
    end

    always_comb begin
        f7   = 7'b0000000;
        f3   = 3'b000;
        word = 32'h0;
        case (bus.in_alu)
            2'b00: begin f7 = 7'b0000000; f3 = 3'b000; end
            2'b01: begin f7 = 7'b0100000; f3 = 3'b000; end
            2'b10: begin f7 = 7'b0000000; f3 = 3'b111; end
            default: begin f7 = 7'b0000000; f3 = 3'b110; end
        endcase
        case (kind)
            KIND_R:
                word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
            KIND_LW:
                word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
            KIND_SW:
                word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                        bus.in_imm[4:0], 7'b0100011};
            default:
                word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                        bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        endcase
    end

    // Storage has no reset; occupancy and head pointer decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[tail] <= word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
            head    <= 1'b0;
            count   <= 2'd0;
            addr    <= BASE_ADDR;
            wcount  <= 16'd0;
            errv    <= 1'b0;
            errc    <= ERR_NONE;
        end else begin
            started <= 1'b1;
            if (flush) begin
                head   <= 1'b0;
                count  <= 2'd0;
                addr   <= BASE_ADDR;
                wcount <= 16'd0;
                errv   <= 1'b0;
                errc   <= ERR_NONE;
            end else begin
                if (pop) begin
                    head <= ~head;
                    addr <= addr + ADDR_W'(4);
                    if (wcount != 16'hFFFF)
                        wcount <= wcount + 16'd1;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
                errv  <= accept && (code != ERR_NONE);
                errc  <= accept ? code : ERR_NONE;
            end
        end
    end

    assign bus.out_valid  = (count != 2'd0);
    assign bus.out_instr  = (count != 2'd0) ? mem[head] : 32'h0;
    assign bus.out_addr   = addr;
    assign bus.err_valid  = errv;
    assign bus.err_code   = errc;
    assign bus.word_count = wcount;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed table, stall/flush/reset
// sequences, randomized traffic against a field-arithmetic reference model.
module tb_rv_instr_encoder;

    logic clk;
    logic reset;
    logic flush;
    logic flush2;

    rv_instr_encoder_if #(.ADDR_W(32)) bus ();
    rv_instr_encoder_if #(.ADDR_W(32)) bus2 ();

    rv_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus.slave)
    );

    rv_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'hFFFFFFF8)) dut2 (
        .clk(clk), .reset(reset), .flush(flush2), .bus(bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed;
    int          total;
    logic [31:0] q[$];
    logic [31:0] model_addr;
    int          model_count;
    logic        mon_en;
    logic        rand_mode;
    logic        man_ready;
    logic        rnd_ready;

    assign bus.out_ready = rand_mode ? rnd_ready : man_ready;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom % 3) != 0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    // Reference encoding built from the instruction field layout with plain arithmetic.
    function automatic logic [31:0] modelWord(input int kind, input int alu, input int rd,
                                              input int rs1, input int rs2, input int unsigned u);
        int unsigned f3tab[4] = '{0, 0, 7, 6};
        int unsigned regs;
        int unsigned w;
        regs = (rs2 << 20) + (rs1 << 15);
        case (kind)
            0: w = ((alu == 1) ? (32 << 25) : 0) + regs + (f3tab[alu] << 12) + (rd << 7) + 51;
            1: w = ((u % 4096) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 3;
            2: w = (((u / 32) % 128) << 25) + regs + (2 << 12) + ((u % 32) << 7) + 35;
            default: w = ((u / 4096) << 31) + (((u / 32) % 64) << 25) + regs
                         + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 99;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] modelErr(input int kind, input int unsigned u);
        int sv;
        sv = (u >= 4096) ? int'(u) - 8192 : int'(u);
        if ((kind == 1 || kind == 2) && (sv < -2048 || sv > 2047)) return 2'b01;
        if (kind == 3 && (u % 2) == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic applyStimulus(input logic [1:0] kind, input logic [1:0] alu,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [12:0] imm,
                                 input logic [31:0] exp_word, input logic [1:0] exp_err);
        int waited;
        bus.in_kind  = kind;
        bus.in_alu   = alu;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (exp_err == 2'b00)
            q.push_back(exp_word);
        checkOutput("err_valid", {31'b0, bus.err_valid}, {31'b0, exp_err != 2'b00});
        checkOutput("err_code", {30'b0, bus.err_code}, {30'b0, exp_err});
    endtask

    task automatic sendModel(input int kind, input int alu, input int rd, input int rs1,
                             input int rs2, input int unsigned u);
        applyStimulus(2'(kind), 2'(alu), 5'(rd), 5'(rs1), 5'(rs2), 13'(u),
                      modelWord(kind, alu, rd, rs1, rs2, u), modelErr(kind, u));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0)
            checkOutput("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic restart();
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        q.delete();
        model_addr  = 32'h0;
        model_count = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    // Scoreboard: every output handshake must match the oldest expected word and address.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            checkOutput("occupancy", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
            if (bus.out_valid && bus.out_ready && !flush && q.size() != 0) begin
                checkOutput("out_instr", bus.out_instr, q[0]);
                checkOutput("out_addr", bus.out_addr, model_addr);
                void'(q.pop_front());
                model_addr = model_addr + 32'd4;
                if (model_count < 65535) model_count++;
            end
        end
    end

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] word;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] held;
        logic [31:0] bexp[3];
        int          bidx;
        int unsigned u;
        int          k;

        passed = 0; total = 0;
        q.delete();
        model_addr = 32'h0; model_count = 0;
        mon_en = 1'b0; rand_mode = 1'b0; man_ready = 1'b1;
        reset = 1'b1; flush = 1'b0; flush2 = 1'b0;
        bus.in_valid = 1'b0; bus.in_kind = 2'b00; bus.in_alu = 2'b00;
        bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_imm = 13'd0;
        bus2.in_valid = 1'b0; bus2.in_kind = 2'b00; bus2.in_alu = 2'b00;
        bus2.in_rd = 5'd1; bus2.in_rs1 = 5'd2; bus2.in_rs2 = 5'd3; bus2.in_imm = 13'd0;
        bus2.out_ready = 1'b1;

        vecs[0] = '{2'b00, 2'b00, 5'd1, 5'd2, 5'd3, 13'd0,     32'h003100B3, 2'b00};
        vecs[1] = '{2'b01, 2'b00, 5'd5, 5'd6, 5'd0, 13'h1FFC,  32'hFFC32283, 2'b00};
        vecs[2] = '{2'b10, 2'b00, 5'd0, 5'd6, 5'd5, 13'd8,     32'h00532423, 2'b00};
        vecs[3] = '{2'b11, 2'b00, 5'd0, 5'd1, 5'd2, 13'h1FF8,  32'hFE208CE3, 2'b00};
        vecs[4] = '{2'b00, 2'b01, 5'd1, 5'd2, 5'd3, 13'd0,     32'h403100B3, 2'b00};
        vecs[5] = '{2'b00, 2'b10, 5'd1, 5'd2, 5'd3, 13'd0,     32'h003170B3, 2'b00};
        vecs[6] = '{2'b00, 2'b11, 5'd1, 5'd2, 5'd3, 13'd0,     32'h003160B3, 2'b00};
        vecs[7] = '{2'b01, 2'b00, 5'd5, 5'd6, 5'd0, 13'h0800,  32'h0,        2'b01};
        vecs[8] = '{2'b11, 2'b00, 5'd0, 5'd1, 5'd2, 13'd3,     32'h0,        2'b10};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_instr", bus.out_instr, 32'h0);
        checkOutput("rst_out_addr", bus.out_addr, 32'h0);
        checkOutput("rst_err_valid", {31'b0, bus.err_valid}, 32'd0);
        checkOutput("rst_err_code", {30'b0, bus.err_code}, 32'd0);
        checkOutput("rst_word_count", {16'b0, bus.word_count}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("in_ready_after_rst", {31'b0, bus.in_ready}, 32'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].kind, vecs[i].alu, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                          vecs[i].imm, vecs[i].word, vecs[i].err);
            if (vecs[i].err != 2'b00) begin
                @(posedge clk); #1;
                checkOutput("err_pulse_drop", {31'b0, bus.err_valid}, 32'd0);
                checkOutput("err_code_drop", {30'b0, bus.err_code}, 32'd0);
            end
        end
        drain();
        checkOutput("table_word_count", {16'b0, bus.word_count}, 32'd7);
        checkOutput("table_addr", bus.out_addr, 32'd28);

        // Stall: two words fill the buffer, third request must wait.
        man_ready = 1'b0;
        sendModel(0, 0, 7, 8, 9, 0);
        sendModel(1, 0, 10, 11, 0, 100);
        held = modelWord(0, 0, 7, 8, 9, 0);
        bus.in_kind = 2'b10; bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
            checkOutput("stall_instr", bus.out_instr, held);
            checkOutput("stall_addr", bus.out_addr, model_addr);
            @(posedge clk); #1;
        end
        man_ready = 1'b1;
        sendModel(2, 0, 0, 12, 13, 4095 - 4096 + 8192);
        drain();

        // Randomized traffic with random back-pressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom % 4);
            u = $urandom % 8192;
            if (($urandom % 10) < 7) begin
                if (k == 1 || k == 2) u = (($urandom % 4096) + 6144) % 8192;
                if (k == 3) u = u - (u % 2);
            end
            sendModel(k, int'($urandom % 4), int'($urandom % 32), int'($urandom % 32),
                      int'($urandom % 32), u);
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end
        rand_mode = 1'b0;
        man_ready = 1'b1;
        drain();
        checkOutput("rand_word_count", {16'b0, bus.word_count}, 32'(model_count));
        checkOutput("rand_addr", bus.out_addr, model_addr);

        // Flush with two buffered words and word_count at 5.
        restart();
        for (int n = 0; n < 5; n++) sendModel(0, n % 4, n, n + 1, n + 2, 0);
        drain();
        checkOutput("pre_flush_count", {16'b0, bus.word_count}, 32'd5);
        man_ready = 1'b0;
        sendModel(0, 0, 1, 1, 1, 0);
        sendModel(3, 0, 0, 1, 1, 16);
        mon_en = 1'b0;
        bus.in_kind = 2'b00; bus.in_valid = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("flush_addr", bus.out_addr, 32'h0);
        checkOutput("flush_count", {16'b0, bus.word_count}, 32'd0);
        q.delete();
        model_addr = 32'h0; model_count = 0;
        man_ready = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Async reset while a word is waiting.
        sendModel(0, 0, 3, 4, 5, 0);
        sendModel(1, 0, 3, 4, 0, 40);
        drain();
        man_ready = 1'b0;
        sendModel(0, 1, 6, 7, 8, 0);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("async_out_instr", bus.out_instr, 32'h0);
        checkOutput("async_addr", bus.out_addr, 32'h0);
        checkOutput("async_count", {16'b0, bus.word_count}, 32'd0);
        q.delete();
        model_addr = 32'h0; model_count = 0;
        man_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Address wrap on the instance based near the top of the address space.
        bexp[0] = 32'hFFFFFFF8; bexp[1] = 32'hFFFFFFFC; bexp[2] = 32'h00000000;
        bidx = 0;
        bus2.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 2) bus2.in_valid = 1'b0;
            if (bus2.out_valid) begin
                if (bidx < 3) checkOutput("wrap_addr", bus2.out_addr, bexp[bidx]);
                checkOutput("wrap_instr", bus2.out_instr, 32'h003100B3);
                bidx++;
            end
        end
        checkOutput("wrap_words", 32'(bidx), 32'd3);
        checkOutput("wrap_count", {16'b0, bus2.word_count}, 32'd3);
        checkOutput("wrap_final_addr", bus2.out_addr, 32'h4);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
